// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor conditioning front end.
// Holds the event index width, handshake state encoding and the priority helper.
package sensor_pkg;

  localparam int SENSOR_IDX_W            = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [SENSOR_IDX_W-1:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = SENSOR_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchroniser, persistence counter and accepted stable level.
// ACTIVE_LOW pads are folded to active-high so a reset synchroniser reads as released.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_raw,
  output logic o_clean
);

  logic             w_level;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  assign w_level = i_raw ^ ACTIVE_LOW;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= w_level;
      r_sync2 <= r_sync1;
      // Any return to the accepted level restarts the persistence count.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clean = r_stable;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces sensor pads and controller buttons, detects sensor rises and
// serialises them as lowest-index-first events over a valid/ack handshake.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int N_SENSOR        = 24,
  parameter int N_CTRL          = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_SENSOR-1:0]     raw_sensor,
  input  logic [N_CTRL-1:0]       raw_ctrl,
  output logic [31:0]             sensor_clean,
  output logic [31:0]             ctrl_clean,
  output logic [N_SENSOR-1:0]     sensor_rise,
  output logic                    event_valid,
  output logic [SENSOR_IDX_W-1:0] event_code,
  input  logic                    event_ack,
  output logic                    overrun
);

  logic [N_SENSOR-1:0]     w_sensor_stable;
  logic [N_CTRL-1:0]       w_ctrl_stable;
  logic [N_SENSOR-1:0]     r_stable_d;
  logic [N_SENSOR-1:0]     r_rise;
  logic [N_SENSOR-1:0]     r_pending;
  logic [N_SENSOR-1:0]     w_clr;
  logic                    w_accept;
  logic                    r_overrun;
  state_t                  r_state;
  state_t                  w_state_next;
  logic [SENSOR_IDX_W-1:0] r_code;
  logic [SENSOR_IDX_W-1:0] w_code_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSOR; gi++) begin : g_sensor
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .ACTIVE_LOW     (1'b0)
      ) u_deb (
        .clock  (clock),
        .resetn (resetn),
        .i_raw  (raw_sensor[gi]),
        .o_clean(w_sensor_stable[gi])
      );
    end
    for (gi = 0; gi < N_CTRL; gi++) begin : g_ctrl
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .ACTIVE_LOW     (1'b1)
      ) u_deb (
        .clock  (clock),
        .resetn (resetn),
        .i_raw  (raw_ctrl[gi]),
        .o_clean(w_ctrl_stable[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_accept     = 1'b0;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_code_next  = lowest_set(32'(r_pending));
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (event_ack) begin
          w_accept     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_accept) w_clr = N_SENSOR'(1) << r_code;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stable_d <= '0;
      r_rise     <= '0;
      r_pending  <= '0;
      r_overrun  <= 1'b0;
      r_state    <= ST_IDLE;
      r_code     <= '0;
    end else begin
      r_stable_d <= w_sensor_stable;
      r_rise     <= w_sensor_stable & ~r_stable_d;
      // Set beats clear so a rise coinciding with its own ack is kept.
      r_pending  <= (r_pending & ~w_clr) | r_rise;
      if (|(r_rise & r_pending & ~w_clr)) r_overrun <= 1'b1;
      r_state    <= w_state_next;
      r_code     <= w_code_next;
    end
  end

  assign sensor_clean = 32'(w_sensor_stable);
  assign ctrl_clean   = 32'(w_ctrl_stable);
  assign sensor_rise  = r_rise;
  assign event_valid  = (r_state == ST_PRESENT);
  assign event_code   = r_code;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus random pad/ack traffic against a
// cycle-level behavioural model (persistence window + pending-set protocol).
module tb_sensor_conditioner;

  localparam int NS  = 24;
  localparam int NC  = 3;
  localparam int DEB = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [NS-1:0] raw_sensor = '0;
  logic [NC-1:0] raw_ctrl = '1;
  logic          event_ack = 1'b0;
  logic [31:0]   sensor_clean;
  logic [31:0]   ctrl_clean;
  logic [NS-1:0] sensor_rise;
  logic          event_valid;
  logic [4:0]    event_code;
  logic          overrun;

  sensor_conditioner #(
    .N_SENSOR(NS), .N_CTRL(NC), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)
  ) dut (
    .clock(clock), .resetn(resetn), .raw_sensor(raw_sensor), .raw_ctrl(raw_ctrl),
    .sensor_clean(sensor_clean), .ctrl_clean(ctrl_clean), .sensor_rise(sensor_rise),
    .event_valid(event_valid), .event_code(event_code), .event_ack(event_ack),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [NS-1:0]  m_ps1, m_ps2, m_sst, m_rise, m_rise_nxt, m_pend;
  logic [NC-1:0]  m_pc1, m_pc2, m_cst;
  logic [DEB-1:0] m_hs [NS];
  logic [DEB-1:0] m_hc [NC];
  logic           m_busy, m_ovr;
  logic [4:0]     m_code;

  function automatic logic [4:0] lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_ps1 = '0; m_ps2 = '0; m_sst = '0; m_rise = '0; m_rise_nxt = '0; m_pend = '0;
    m_pc1 = '0; m_pc2 = '0; m_cst = '0;
    for (int i = 0; i < NS; i++) m_hs[i] = '0;
    for (int i = 0; i < NC; i++) m_hc[i] = '0;
    m_busy = 1'b0; m_ovr = 1'b0; m_code = '0;
  endtask

  // A level is accepted once the synchronised input has shown the opposite
  // value for DEB consecutive clocks (window of the last DEB samples).
  task automatic model_edge();
    logic [NS-1:0] clr, ns;
    logic [NC-1:0] nc;
    if (!resetn) begin
      model_reset();
      return;
    end
    clr = '0;
    if (m_busy && event_ack) clr[m_code] = 1'b1;
    if (|(m_rise & m_pend & ~clr)) m_ovr = 1'b1;
    if (!m_busy) begin
      if (m_pend != '0) begin
        m_code = lowest(m_pend);
        m_busy = 1'b1;
      end
    end else if (event_ack) begin
      m_busy = 1'b0;
      $display("event accepted: code=%0d", m_code);
    end
    m_pend = (m_pend & ~clr) | m_rise;
    m_rise = m_rise_nxt;
    for (int i = 0; i < NS; i++) begin
      m_hs[i] = {m_hs[i][DEB-2:0], m_ps2[i]};
      if (!m_sst[i] && (&m_hs[i]))          ns[i] = 1'b1;
      else if (m_sst[i] && (m_hs[i] == '0)) ns[i] = 1'b0;
      else                                  ns[i] = m_sst[i];
    end
    for (int i = 0; i < NC; i++) begin
      m_hc[i] = {m_hc[i][DEB-2:0], m_pc2[i]};
      if (!m_cst[i] && (&m_hc[i]))          nc[i] = 1'b1;
      else if (m_cst[i] && (m_hc[i] == '0)) nc[i] = 1'b0;
      else                                  nc[i] = m_cst[i];
    end
    m_rise_nxt = ns & ~m_sst;
    m_sst = ns;
    m_cst = nc;
    m_ps2 = m_ps1; m_ps1 = raw_sensor;
    m_pc2 = m_pc1; m_pc1 = ~raw_ctrl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sensor_clean", sensor_clean, 32'(m_sst));
    chk("ctrl_clean",   ctrl_clean,   32'(m_cst));
    chk("sensor_rise",  32'(sensor_rise), 32'(m_rise));
    chk("event_valid",  32'(event_valid), 32'(m_busy));
    chk("event_code",   32'(event_code),  32'(m_code));
    chk("overrun",      32'(overrun),     32'(m_ovr));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      event_ack = 1'b1;
      step();
      if (m_pend == '0 && !m_busy) done = 1;
    end
    event_ack = 1'b0;
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rise_cnt;
    bit hit;
    logic [4:0] codes [$];
    logic [NS-1:0] mask;
    model_reset();
    @(negedge clock);

    // Reset: pads toggling, everything must stay 0
    resetn = 1'b0;
    repeat (6) begin
      raw_sensor = NS'($urandom); raw_ctrl = NC'($urandom); event_ack = 1'($urandom);
      step();
    end
    raw_sensor = '0; raw_ctrl = 3'b111; event_ack = 1'b0; resetn = 1'b1;
    repeat (12) step();
    chk("ctrl_idle_after_reset", ctrl_clean, 32'd0);

    // Debounce: short pulse rejected, long pulse accepted with fixed latency
    raw_sensor[3] = 1'b1; repeat (7) step();
    raw_sensor[3] = 1'b0; repeat (12) step();
    chk("glitch_rejected", 32'(sensor_clean[3]), 32'd0);
    raw_sensor[3] = 1'b1;
    rise_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("deb_latency", 32'(sensor_clean[3]), (k >= 10) ? 32'd1 : 32'd0);
      if (sensor_rise[3]) rise_cnt++;
    end
    chk("rise_once", 32'(rise_cnt), 32'd1);
    drain();

    // Handshake: held presentation, then ack
    raw_sensor[5] = 1'b1; repeat (14) step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("hold_valid", 32'(event_valid), 32'd1);
      chk("hold_code",  32'(event_code),  32'd5);
    end
    event_ack = 1'b1; step(); event_ack = 1'b0;
    chk("ack_drops_valid", 32'(event_valid), 32'd0);
    repeat (3) step();
    chk("no_repeat_after_ack", 32'(event_valid), 32'd0);

    // Priority: ch9 and ch2 rise together
    raw_sensor[9] = 1'b1; raw_sensor[2] = 1'b1;
    event_ack = 1'b1;
    repeat (30) begin
      step();
      if (event_valid) codes.push_back(event_code);
    end
    event_ack = 1'b0;
    chk("prio_count", 32'(codes.size()), 32'd2);
    if (codes.size() >= 2) begin
      chk("prio_first",  32'(codes[0]), 32'd2);
      chk("prio_second", 32'(codes[1]), 32'd9);
    end

    // Collision: new rise on ch5 in the same cycle ch5 is acked
    raw_sensor[5] = 1'b0; repeat (12) step();
    raw_sensor[5] = 1'b1; repeat (14) step();
    raw_sensor[5] = 1'b0; repeat (12) step();
    raw_sensor[5] = 1'b1;
    hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      event_ack = m_rise[5] && m_busy && (m_code == 5'd5);
      step();
      if (event_ack) hit = 1;
    end
    event_ack = 1'b0;
    chk("collision_reached", 32'(hit), 32'd1);
    repeat (4) step();
    chk("collision_kept_valid", 32'(event_valid), 32'd1);
    chk("collision_kept_code",  32'(event_code),  32'd5);
    chk("collision_no_overrun", 32'(overrun),     32'd0);

    // Overrun: second rise while ch5 still pending
    raw_sensor[5] = 1'b0; repeat (12) step();
    raw_sensor[5] = 1'b1; repeat (14) step();
    chk("overrun_set", 32'(overrun), 32'd1);
    drain();

    // Controller button 0 pressed then released; no event
    raw_ctrl = 3'b110; repeat (12) step();
    chk("ctrl_pressed", ctrl_clean, 32'h1);
    chk("ctrl_no_event", 32'(event_valid), 32'd0);
    raw_ctrl = 3'b111; repeat (12) step();
    chk("ctrl_released", ctrl_clean, 32'h0);

    // Random traffic: occasional pad flips and glitches, random ack
    repeat (1500) begin
      mask = '0;
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 29) == 0) mask[i] = 1'b1;
      raw_sensor = raw_sensor ^ mask;
      if ($urandom_range(0, 39) == 0) raw_ctrl = raw_ctrl ^ NC'(1 << $urandom_range(0, NC-1));
      event_ack = 1'($urandom);
      step();
    end
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-activity clears everything including overrun
    resetn = 1'b0; repeat (3) step();
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_valid", 32'(event_valid), 32'd0);
    raw_ctrl = 3'b111; resetn = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 9) == 0) raw_sensor = raw_sensor ^ NS'(1 << $urandom_range(0, NS-1));
      event_ack = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
